wb_stream_fifo: RTL and testbench
=================================

Name: wb_stream_fifo

Overview:
- Wishbone classic slave that sits directly downstream of the GPMC-to-Wishbone bridge and consumes its strobe, cycle, write, address and write-data outputs.
- Gives the host a register-mapped pair of FIFOs:
  - TX, host to fabric: drained by fabric logic through a valid/ready stream.
  - RX, fabric to host: filled by fabric logic through a valid/ready stream and popped by host reads.
- Bridge strobes last many clk cycles, so each access is edge-qualified and executes exactly once.

Parameters:
- DEPTH, 16, entries per FIFO; power of 2, range 2..128.
- DATA_WIDTH, 16, FIFO word and bus data width.
- ADDR_WIDTH, 16, Wishbone address width.
- BASE_ADDR, 16'h0000, block base; decode uses address[15:2] only.
- CW (derived), log2(DEPTH)+1, count width.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- wbs_address  in  16  word address from bridge.
- wbs_writedata  in  16  write data from bridge.
- wbs_readdata  out  16  registered read data.
- wbs_strobe  in  1  data strobe.
- wbs_cycle  in  1  bus cycle in progress.
- wbs_write  in  1  1 = write access.
- wbs_ack  out  1  single-cycle acknowledge.
- tx_data  out  16  TX FIFO head.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  fabric accepts tx_data.
- rx_data  in  16  fabric word to host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO can accept.
- irq  out  1  level interrupt: RX non-empty or any sticky error flag set.

Behaviour:
- Reset, asynchronous:
  - Outputs: wbs_ack=0, wbs_readdata=0, tx_valid=0, rx_ready=0, irq=0.
  - Internal: pointers, counts and sticky flags cleared.
  - After reset deasserts, rx_ready=1.
  - Reset mid-transfer discards both FIFO contents and any pending ack.
- Request detection:
  - req = wbs_cycle & wbs_strobe & (wbs_address[15:2]==BASE_ADDR[15:2]).
  - req_d is req registered. An access fires on req & !req_d.
  - No further action while req stays high. A new access needs req to drop for at least 1 cycle.
- Ack:
  - wbs_ack goes high exactly 1 cycle after the firing edge, for 1 cycle only.
  - On reads, wbs_readdata updates in the same cycle as wbs_ack and holds until the next read.
  - Non-decoded addresses never ack.
- Register map (offset = wbs_address[1:0]):
  - 0 DATA.
    - Write pushes wbs_writedata into TX. If TX is full, the word is dropped and tx_ovf is set.
    - Read pops RX and returns its head. If RX is empty, returns 0 and sets rx_unf.
  - 1 STATUS, read-only; writes are acked and ignored.
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tx_ovf, [5] rx_unf, [6] rx_ovf.
    - [15:8] rx_count, zero-extended.
  - 2 CONTROL, write-only; reads return 0.
    - bit0 flushes TX, bit1 flushes RX, bit2 clears all sticky flags.
    - Actions take effect on the firing cycle.
  - 3 TX_COUNT: read returns tx_count, zero-extended; writes are ignored.
- FIFOs:
  - Circular buffers with CW-bit pointers; full/empty derived from the pointer MSB.
  - tx_valid = !tx_empty. tx_data = TX head, combinational from storage.
  - TX pops on tx_valid & tx_ready.
  - rx_ready = !rx_full & !reset. RX pushes on rx_valid & rx_ready.
  - rx_ovf is set if rx_valid is high while rx_full is set; that word is lost.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both occur and the count is unchanged. This is legal at full for TX: a fabric pop plus a host push at full is accepted, with no tx_ovf.
  - Flush has priority over a same-cycle push or pop on that FIFO. The FIFO ends empty and the pushed word is dropped without setting a flag.
  - Clearing sticky flags has priority over a same-cycle set.
- Counts never exceed DEPTH; pointers wrap modulo 2*DEPTH.

Test Plan:
- Reset, then read STATUS → 16'h000A: tx_empty and rx_empty set, counts 0; irq=0, rx_ready=1.
- Write DATA 16'hA5A5 with strobe held 20 cycles → exactly one ack, 1 cycle after the strobe edge; TX_COUNT=1; tx_valid=1, tx_data=16'hA5A5. Pulse tx_ready → tx_valid=0.
- Hold tx_ready=0 and write DEPTH+1 words 0..16 → TX_COUNT=16; STATUS[0]=1, STATUS[4]=1; irq=1. Drain returns 0..15 in order; write CONTROL=4 → STATUS[4]=0.
- Fabric pushes 3 words 16'h0011/22/33 → rx_count=3, irq=1. Three DATA reads return them in order; a 4th read returns 0 with STATUS[5]=1.
- Fill RX to 16 and keep rx_valid high 1 more cycle → rx_ready=0, rx_ovf=1. A host read and fabric push in the same cycle leave the count at 16 after rx_ready reasserts.
- Write CONTROL=3 while both FIFOs hold 5 words, with a same-cycle tx pop → both counts 0; assert reset mid-read strobe → wbs_ack never pulses and all outputs go to reset values immediately.

Source files
------------

// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: Wishbone classic slave exposing a TX (host->fabric) and an
// RX (fabric->host) FIFO through a four-word register window. Bridge strobes
// are long, so every access is qualified on the rising edge of the decoded
// request and executes exactly once.
module wb_stream_fifo #(
  parameter int                    DEPTH      = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  input  logic                  wbs_write,
  output logic                  wbs_ack,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);

  // Storage and pointers; pointers carry one extra wrap bit
  logic [DATA_WIDTH-1:0] tx_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_r [DEPTH];
  logic [CW-1:0]         tx_wr_ptr_r, tx_rd_ptr_r;
  logic [CW-1:0]         rx_wr_ptr_r, rx_rd_ptr_r;

  // Sticky error flags, bus handshake state and registered outputs
  logic                  tx_ovf_r, rx_unf_r, rx_ovf_r;
  logic                  req_d_r, ack_r, irq_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  // Derived FIFO state
  logic [CW-1:0]         tx_count_s, rx_count_s;
  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic                  rx_ready_s;

  // Bus decode and per-cycle events
  logic                  req_s, fire_s;
  logic [1:0]            offset_s;
  logic                  data_wr_s, data_rd_s, ctrl_wr_s;
  logic                  tx_flush_s, rx_flush_s, flag_clr_s;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic                  tx_ovf_set_s, rx_unf_set_s, rx_ovf_set_s;
  logic [DATA_WIDTH-1:0] status_s, rd_data_s;

  assign tx_count_s = tx_wr_ptr_r - tx_rd_ptr_r;
  assign rx_count_s = rx_wr_ptr_r - rx_rd_ptr_r;
  assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
  assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
  assign tx_full_s  = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                      (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
  assign rx_full_s  = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                      (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);

  // rx_ready is forced low while reset is asserted, not just after the flop
  assign rx_ready_s = ~rx_full_s & ~reset;

  assign req_s    = wbs_cycle & wbs_strobe &
                    (wbs_address[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
  assign fire_s   = req_s & ~req_d_r;
  assign offset_s = wbs_address[1:0];

  assign data_wr_s  = fire_s &  wbs_write & (offset_s == 2'd0);
  assign data_rd_s  = fire_s & ~wbs_write & (offset_s == 2'd0);
  assign ctrl_wr_s  = fire_s &  wbs_write & (offset_s == 2'd2);
  assign tx_flush_s = ctrl_wr_s & wbs_writedata[0];
  assign rx_flush_s = ctrl_wr_s & wbs_writedata[1];
  assign flag_clr_s = ctrl_wr_s & wbs_writedata[2];

  // A host push at full is still accepted when the fabric pops the same cycle
  assign tx_pop_s     = ~tx_empty_s & tx_ready;
  assign tx_push_s    = data_wr_s & (~tx_full_s | tx_pop_s);
  assign tx_ovf_set_s = data_wr_s & tx_full_s & ~tx_pop_s;
  assign rx_push_s    = rx_valid & rx_ready_s;
  assign rx_pop_s     = data_rd_s & ~rx_empty_s;
  assign rx_unf_set_s = data_rd_s & rx_empty_s;
  assign rx_ovf_set_s = rx_valid & rx_full_s;

  // Status word and read-data mux sampled at the firing edge
  always_comb begin
    status_s      = '0;
    status_s[0]   = tx_full_s;
    status_s[1]   = tx_empty_s;
    status_s[2]   = rx_full_s;
    status_s[3]   = rx_empty_s;
    status_s[4]   = tx_ovf_r;
    status_s[5]   = rx_unf_r;
    status_s[6]   = rx_ovf_r;
    status_s[15:8] = 8'(rx_count_s);
    rd_data_s     = '0;
    case (offset_s)
      2'd0: begin
        if (rx_empty_s) begin
          rd_data_s = '0;
        end else begin
          rd_data_s = rx_mem_r[rx_rd_ptr_r[AW-1:0]];
        end
      end
      2'd1:    rd_data_s = status_s;
      2'd2:    rd_data_s = '0;
      2'd3:    rd_data_s = DATA_WIDTH'(tx_count_s);
      default: rd_data_s = '0;
    endcase
  end

  // Bus handshake, FIFO pointers, sticky flags and interrupt register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d_r     <= 1'b0;
      ack_r       <= 1'b0;
      rdata_r     <= '0;
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      tx_ovf_r    <= 1'b0;
      rx_unf_r    <= 1'b0;
      rx_ovf_r    <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      req_d_r <= req_s;
      ack_r   <= fire_s;
      if (fire_s && !wbs_write) begin
        rdata_r <= rd_data_s;
      end
      if (tx_flush_s) begin
        tx_rd_ptr_r <= tx_wr_ptr_r;
      end else begin
        if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
        if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      end
      if (rx_flush_s) begin
        rx_rd_ptr_r <= rx_wr_ptr_r;
      end else begin
        if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
        if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      end
      if (flag_clr_s) begin
        tx_ovf_r <= 1'b0;
        rx_unf_r <= 1'b0;
        rx_ovf_r <= 1'b0;
      end else begin
        if (tx_ovf_set_s) tx_ovf_r <= 1'b1;
        if (rx_unf_set_s) rx_unf_r <= 1'b1;
        if (rx_ovf_set_s) rx_ovf_r <= 1'b1;
      end
      irq_r <= ~rx_empty_s | tx_ovf_r | rx_unf_r | rx_ovf_r;
    end
  end

  // FIFO storage writes; a same-cycle flush discards the incoming word
  always_ff @(posedge clk) begin
    if (tx_push_s && !tx_flush_s) begin
      tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= wbs_writedata;
    end
    if (rx_push_s && !rx_flush_s) begin
      rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_data;
    end
  end

  assign wbs_ack      = ack_r;
  assign wbs_readdata = rdata_r;
  assign tx_data      = tx_mem_r[tx_rd_ptr_r[AW-1:0]];
  assign tx_valid     = ~tx_empty_s;
  assign rx_ready     = rx_ready_s;
  assign irq          = irq_r;

endmodule

// File: tb/tb_wb_stream_fifo.sv
// Directed testbench for wb_stream_fifo: register map, edge-qualified access,
// FIFO ordering, boundary flags, flush/clear priority and async reset.
module tb_wb_stream_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wbs_address;
  logic [15:0] wbs_writedata;
  logic [15:0] wbs_readdata;
  logic        wbs_strobe, wbs_cycle, wbs_write, wbs_ack;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready, irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] rd;
  int          acks, acyc;

  wb_stream_fifo dut (
    .clk(clk), .reset(reset),
    .wbs_address(wbs_address), .wbs_writedata(wbs_writedata),
    .wbs_readdata(wbs_readdata), .wbs_strobe(wbs_strobe),
    .wbs_cycle(wbs_cycle), .wbs_write(wbs_write), .wbs_ack(wbs_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus access with strobe held for 'hold' cycles; optional tx_ready pulse in the firing cycle
  task automatic bus_xfer(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                          input int hold, input logic pop_tx,
                          output logic [15:0] rdata, output int n_ack, output int ack_cyc);
    n_ack   = 0;
    ack_cyc = -1;
    rdata   = 16'hDEAD;
    @(posedge clk); #1;
    wbs_address   = addr;
    wbs_writedata = wdata;
    wbs_write     = wr;
    wbs_cycle     = 1'b1;
    wbs_strobe    = 1'b1;
    if (pop_tx) tx_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (wbs_ack === 1'b1) begin
        if (n_ack == 0) begin
          ack_cyc = i;
          rdata   = wbs_readdata;
        end
        n_ack++;
      end
      @(posedge clk);
      if (i == 0 && pop_tx) begin
        #1 tx_ready = 1'b0;
      end
    end
    #1;
    wbs_cycle  = 1'b0;
    wbs_strobe = 1'b0;
    wbs_write  = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [15:0] data);
    logic [15:0] d;
    int          a, c;
    bus_xfer({14'h0, off}, 1'b1, data, 3, 1'b0, d, a, c);
  endtask

  task automatic reg_read(input logic [1:0] off, output logic [15:0] data);
    int a, c;
    bus_xfer({14'h0, off}, 1'b0, 16'h0000, 3, 1'b0, data, a, c);
  endtask

  task automatic tx_pop_one();
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
  endtask

  // Fabric streams n consecutive words base, base+1, ... into RX
  task automatic rx_stream(input logic [15:0] base, input int n);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      rx_data = base + 16'(i);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wbs_address = 16'h0000; wbs_writedata = 16'h0000;
    wbs_strobe = 1'b0; wbs_cycle = 1'b0; wbs_write = 1'b0;
    tx_ready = 1'b0; rx_data = 16'h0000; rx_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", wbs_ack, 1'b0);
    check("rst_rdata", wbs_readdata, 16'h0000);
    check("rst_txvalid", tx_valid, 1'b0);
    check("rst_rxready", rx_ready, 1'b0);
    check("rst_irq", irq, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_rxready", rx_ready, 1'b1);
    reg_read(2'd1, rd);
    check("status_idle", rd, 16'h000A);
    check("irq_idle", irq, 1'b0);

    // Undecoded addresses never ack and have no effect
    bus_xfer(16'h0004, 1'b0, 16'h0000, 4, 1'b0, rd, acks, acyc);
    check("undecoded_rd_acks", acks, 0);
    bus_xfer(16'h0010, 1'b1, 16'h1234, 4, 1'b0, rd, acks, acyc);
    check("undecoded_wr_acks", acks, 0);
    reg_read(2'd3, rd);
    check("undecoded_txcount", rd, 16'h0000);

    // Long strobe executes once
    bus_xfer(16'h0000, 1'b1, 16'hA5A5, 20, 1'b0, rd, acks, acyc);
    check("long_strobe_acks", acks, 1);
    check("long_strobe_ack_cycle", acyc, 1);
    reg_read(2'd3, rd);
    check("txcount_one", rd, 16'h0001);
    @(negedge clk);
    check("txvalid_one", tx_valid, 1'b1);
    check("txdata_a5a5", tx_data, 16'hA5A5);
    tx_pop_one();
    @(negedge clk);
    check("txvalid_drained", tx_valid, 1'b0);

    // STATUS is read-only, CONTROL reads as zero
    reg_write(2'd1, 16'hFFFF);
    reg_read(2'd1, rd);
    check("status_wr_ignored", rd, 16'h000A);
    reg_read(2'd2, rd);
    check("control_reads_zero", rd, 16'h0000);

    // TX overflow
    for (int i = 0; i < 17; i++) reg_write(2'd0, 16'(i));
    reg_read(2'd3, rd);
    check("txcount_full", rd, 16'h0010);
    reg_read(2'd1, rd);
    check("status_tx_full_ovf", rd, 16'h0019);
    check("irq_tx_ovf", irq, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("tx_order_%0d", i), tx_data, 16'(i));
      tx_pop_one();
    end
    @(negedge clk);
    check("tx_empty_after_drain", tx_valid, 1'b0);
    reg_write(2'd2, 16'h0004);
    reg_read(2'd1, rd);
    check("status_ovf_cleared", rd, 16'h000A);
    check("irq_cleared", irq, 1'b0);

    // RX path and underflow
    rx_stream(16'h0011, 0);
    rx_data = 16'h0011; rx_stream(16'h0011, 1);
    rx_stream(16'h0022, 1);
    rx_stream(16'h0033, 1);
    reg_read(2'd1, rd);
    check("status_rx3", rd, 16'h0302);
    check("irq_rx_nonempty", irq, 1'b1);
    reg_read(2'd0, rd);
    check("rx_pop_0", rd, 16'h0011);
    reg_read(2'd0, rd);
    check("rx_pop_1", rd, 16'h0022);
    reg_read(2'd0, rd);
    check("rx_pop_2", rd, 16'h0033);
    reg_read(2'd0, rd);
    check("rx_underflow_data", rd, 16'h0000);
    reg_read(2'd1, rd);
    check("status_rx_unf", rd, 16'h002A);
    check("irq_rx_unf", irq, 1'b1);
    reg_write(2'd2, 16'h0004);

    // RX fill and overflow
    @(posedge clk); #1;
    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 16'h0100 + 16'(i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rx_ready_full", rx_ready, 1'b0);
    rx_valid = 1'b0;
    reg_read(2'd1, rd);
    check("status_rx_full_ovf", rd, 16'h1046);
    rx_valid = 1'b1;
    rx_data  = 16'hBEEF;
    reg_read(2'd0, rd);
    rx_valid = 1'b0;
    check("rx_head_at_full", rd, 16'h0100);
    reg_read(2'd1, rd);
    check("rx_count_refilled", rd[15:8], 8'h10);
    reg_write(2'd2, 16'h0006);
    reg_read(2'd1, rd);
    check("status_rx_flushed", rd, 16'h000A);

    // TX push and pop together at full
    for (int i = 0; i < 16; i++) reg_write(2'd0, 16'h0200 + 16'(i));
    bus_xfer(16'h0000, 1'b1, 16'h0300, 3, 1'b1, rd, acks, acyc);
    reg_read(2'd1, rd);
    check("status_full_pushpop", rd, 16'h0009);
    reg_read(2'd3, rd);
    check("txcount_full_pushpop", rd, 16'h0010);
    @(negedge clk);
    check("txdata_after_pushpop", tx_data, 16'h0201);
    reg_write(2'd2, 16'h0001);

    // Flush both FIFOs with a same-cycle TX pop
    for (int i = 0; i < 5; i++) reg_write(2'd0, 16'h0400 + 16'(i));
    rx_stream(16'h0500, 5);
    reg_read(2'd3, rd);
    check("txcount_5", rd, 16'h0005);
    reg_read(2'd1, rd);
    check("status_rx5", rd, 16'h0500);
    bus_xfer(16'h0002, 1'b1, 16'h0003, 3, 1'b1, rd, acks, acyc);
    reg_read(2'd3, rd);
    check("txcount_flushed", rd, 16'h0000);
    reg_read(2'd1, rd);
    check("status_both_flushed", rd, 16'h000A);
    @(negedge clk);
    check("txvalid_flushed", tx_valid, 1'b0);

    // Reset in the middle of a read strobe
    reg_write(2'd0, 16'h0777);
    rx_stream(16'h0055, 1);
    reg_read(2'd3, rd);
    check("pre_rst_readdata", rd, 16'h0001);
    check("pre_rst_irq", irq, 1'b1);
    @(posedge clk); #1;
    wbs_address = 16'h0000; wbs_write = 1'b0;
    wbs_cycle = 1'b1; wbs_strobe = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_ack", wbs_ack, 1'b0);
    check("midrst_rdata", wbs_readdata, 16'h0000);
    check("midrst_txvalid", tx_valid, 1'b0);
    check("midrst_rxready", rx_ready, 1'b0);
    check("midrst_irq", irq, 1'b0);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wbs_ack === 1'b1) acks++;
    end
    wbs_cycle = 1'b0; wbs_strobe = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wbs_ack === 1'b1) acks++;
    end
    check("midrst_no_ack", acks, 0);
    check("post_rst2_rxready", rx_ready, 1'b1);
    reg_read(2'd1, rd);
    check("status_after_rst", rd, 16'h000A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
